// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - 3x3 Sobel window generator with two line buffers and centre coordinates.
// Optional idle-cycle counter output enabled by SOBEL_WIN_IDLE_CNT_EN.
module sobel_window_gen #(
  parameter int WIDTH   = 512,
  parameter int HEIGHT  = 512,
  parameter int DATA_W  = 8,
  parameter int COORD_W = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  data_en,
  output logic [9*DATA_W-1:0]   window_out,
  output logic                  window_valid,
  output logic [COORD_W-1:0]    center_x,
  output logic [COORD_W-1:0]    center_y,
  output logic                  frame_done
`ifdef SOBEL_WIN_IDLE_CNT_EN
  ,
  output logic [31:0]           idle_cycles
`endif
);

  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(HEIGHT - 1);
  localparam logic [COORD_W-1:0] TWO      = COORD_W'(2);
  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

  logic [DATA_W-1:0]   lb0_q [WIDTH];
  logic [DATA_W-1:0]   lb1_q [WIDTH];

  logic [9*DATA_W-1:0] win_q, win_d;
  logic [COORD_W-1:0]  col_q, col_d;
  logic [COORD_W-1:0]  row_q, row_d;
  logic [COORD_W-1:0]  cx_q, cx_d;
  logic [COORD_W-1:0]  cy_q, cy_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic [AW-1:0]       col_idx;
  logic [DATA_W-1:0]   new_col [3];

  assign col_idx    = col_q[AW-1:0];
  assign new_col[0] = lb1_q[col_idx];
  assign new_col[1] = lb0_q[col_idx];
  assign new_col[2] = data_in;

  always_comb begin
    win_d   = win_q;
    col_d   = col_q;
    row_d   = row_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (data_en) begin
      // Tap columns shift left; the freshly read column enters at c2.
      for (int r = 0; r < 3; r++) begin
        win_d[(3*r+0)*DATA_W +: DATA_W] = win_q[(3*r+1)*DATA_W +: DATA_W];
        win_d[(3*r+1)*DATA_W +: DATA_W] = win_q[(3*r+2)*DATA_W +: DATA_W];
        win_d[(3*r+2)*DATA_W +: DATA_W] = new_col[r];
      end
      valid_d = (col_q >= TWO) && (row_q >= TWO);
      if (valid_d) begin
        cx_d = col_q - ONE;
        cy_d = row_q - ONE;
      end
      if (col_q == LAST_COL) begin
        col_d = '0;
        if (row_q == LAST_ROW) begin
          row_d  = '0;
          done_d = 1'b1;
        end else begin
          row_d = row_q + ONE;
        end
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      win_q   <= win_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Line buffers carry no reset; rows 0/1 never produce a valid window.
  always_ff @(posedge clk) begin
    if (data_en) begin
      lb1_q[col_idx] <= lb0_q[col_idx];
      lb0_q[col_idx] <= data_in;
    end
  end

  assign window_out   = win_q;
  assign window_valid = valid_q;
  assign center_x     = cx_q;
  assign center_y     = cy_q;
  assign frame_done   = done_q;

`ifdef SOBEL_WIN_IDLE_CNT_EN
  logic [31:0] idle_q;
  logic        started_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q    <= '0;
      started_q <= 1'b0;
    end else begin
      if (done_d) begin
        idle_q    <= '0;
        started_q <= 1'b0;
      end else if (data_en) begin
        started_q <= 1'b1;
      end else if (started_q) begin
        idle_q <= idle_q + 32'd1;
      end
    end
  end

  assign idle_cycles = idle_q;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - scoreboard bench for sobel_window_gen on an 8x4 frame.
// Exercises SOBEL_WIN_IDLE_CNT_EN when the macro is defined.
module tb_sobel_window_gen;
  localparam int W = 8;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        data_en;
  logic [71:0] window_out;
  logic        window_valid;
  logic [10:0] center_x;
  logic [10:0] center_y;
  logic        frame_done;
`ifdef SOBEL_WIN_IDLE_CNT_EN
  logic [31:0] idle_cycles;
`endif

  sobel_window_gen #(.WIDTH(W), .HEIGHT(H), .DATA_W(8), .COORD_W(11)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .data_en      (data_en),
    .window_out   (window_out),
    .window_valid (window_valid),
    .center_x     (center_x),
    .center_y     (center_y),
    .frame_done   (frame_done)
`ifdef SOBEL_WIN_IDLE_CNT_EN
    ,
    .idle_cycles  (idle_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          cx;
    int          cy;
    logic [71:0] win;
  } exp_t;

  exp_t        wq[$];
  int          fdq[$];
  int          fd_edges[$];
  int          edge_n = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          vcount = 0;
  int          fdcount = 0;
  int          mx = 0;
  int          my = 0;
  logic [7:0]  img [H][W];
  logic [71:0] win11, win62;

  always @(posedge clk) edge_n = edge_n + 1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  task automatic model_accept(input logic [7:0] p);
    exp_t e;
    img[my][mx] = p;
    if (mx >= 2 && my >= 2) begin
      e.due = edge_n;
      e.cx  = mx - 1;
      e.cy  = my - 1;
      e.win = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.win[(3*r+c)*8 +: 8] = img[my-2+r][mx-2+c];
      wq.push_back(e);
    end
    if (mx == W-1 && my == H-1) fdq.push_back(edge_n);
    if (mx == W-1) begin
      mx = 0;
      my = (my == H-1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
  endtask

  task automatic step(input logic en, input logic [7:0] p);
    data_en = en;
    data_in = p;
    @(posedge clk);
    #1;
    if (en) model_accept(p);
    data_en = 1'b0;
  endtask

  task automatic clear_counts();
    vcount  = 0;
    fdcount = 0;
    fd_edges.delete();
    win11 = '0;
    win62 = '0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (!reset) begin
      if (window_valid) begin
        if (wq.size() == 0) fail_now("unexpected_window_valid");
        else begin
          e = wq.pop_front();
          check("valid_lag", edge_n, e.due);
          check("center_x", center_x, e.cx);
          check("center_y", center_y, e.cy);
          check("window", window_out, e.win);
          if (center_x == 1 && center_y == 1) win11 = window_out;
          if (center_x == 6 && center_y == 2) win62 = window_out;
          vcount++;
        end
      end else if (wq.size() > 0 && wq[0].due <= edge_n) begin
        fail_now("missing_window_valid");
        void'(wq.pop_front());
      end
      if (frame_done) begin
        if (fdq.size() == 0) fail_now("unexpected_frame_done");
        else begin
          d = fdq.pop_front();
          check("frame_done_lag", edge_n, d);
          fd_edges.push_back(edge_n);
          fdcount++;
        end
      end else if (fdq.size() > 0 && fdq[0] <= edge_n) begin
        fail_now("missing_frame_done");
        void'(fdq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    data_en = 1'b0;
    data_in = 8'h00;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check("reset_window", window_out, 72'h0);
    check("reset_valid", window_valid, 0);
    check("reset_cx", center_x, 0);
    check("reset_cy", center_y, 0);
    check("reset_done", frame_done, 0);
    reset = 1'b0;

    // Frame 1: continuous ramp x+16y
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        step(1'b1, 8'(x + 16*y));
    repeat (3) step(1'b0, 8'h00);
    check("f1_valid_count", vcount, 12);
    check("f1_frame_done_count", fdcount, 1);
    check("f1_first_window", win11, 72'h22_21_20_12_11_10_02_01_00);
    check("f1_window_6_2", win62, 72'h37_36_35_27_26_25_17_16_15);
    clear_counts();

    // Frame 2: same data with data_en toggling
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        step(1'b1, 8'(x + 16*y));
        step(1'b0, 8'hEE);
      end
    repeat (3) step(1'b0, 8'h00);
    check("f2_valid_count", vcount, 12);
    check("f2_frame_done_count", fdcount, 1);
    check("f2_window_6_2", win62, 72'h37_36_35_27_26_25_17_16_15);
    clear_counts();

    // Frame 3: reset right after the accept of pixel (5,2)
    for (int i = 0; i < 2*W + 6; i++)
      step(1'b1, 8'h5A ^ 8'(i));
    reset = 1'b1;
    wq.delete();
    fdq.delete();
    mx = 0;
    my = 0;
    #1;
    check("midreset_window", window_out, 72'h0);
    check("midreset_valid", window_valid, 0);
    check("midreset_cx", center_x, 0);
    check("midreset_cy", center_y, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_counts();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        step(1'b1, 8'(255 - (x + 16*y)));
    repeat (3) step(1'b0, 8'h00);
    check("f3_valid_count", vcount, 12);
    check("f3_first_window", win11, 72'hDD_DE_DF_ED_EE_EF_FD_FE_FF);
    clear_counts();

    // Frames 4/5: back to back, no gap
    for (int f = 0; f < 2; f++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          step(1'b1, 8'(3*x + 5*y + 7*f));
    repeat (3) step(1'b0, 8'h00);
    check("b2b_valid_count", vcount, 24);
    check("b2b_frame_done_count", fdcount, 2);
    if (fd_edges.size() == 2) check("b2b_frame_spacing", fd_edges[1] - fd_edges[0], W*H);
    else fail_now("b2b_frame_edges_missing");
    clear_counts();

`ifdef SOBEL_WIN_IDLE_CNT_EN
    for (int i = 0; i < W*H; i++) begin
      if (i == 10) repeat (3) step(1'b0, 8'h00);
      if (i == W*H - 1) check("idle_before_done", idle_cycles, 3);
      step(1'b1, 8'(i));
    end
    check("idle_done_pulse", frame_done, 1);
    check("idle_cleared", idle_cycles, 0);
    repeat (3) step(1'b0, 8'h00);
    clear_counts();
`endif

    check("window_queue_drained", wq.size(), 0);
    check("done_queue_drained", fdq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
